// File: rtl/stq_pkg.sv
// Store-queue shared definitions: queue depth, entry pointer type, one-hot decode
// and the drain-side FSM states.
package stq_pkg;

  localparam int unsigned STQ_BUF_COUNT = 64;
  localparam int unsigned STQ_PTR_W     = $clog2(STQ_BUF_COUNT);

  typedef logic [STQ_PTR_W-1:0] stq_ptr_t;

  typedef enum logic {
    DRAIN_EMPTY = 1'b0,
    DRAIN_FULL  = 1'b1
  } drain_state_e;

  function automatic logic [STQ_BUF_COUNT-1:0] stq_onehot(input stq_ptr_t ptr);
    logic [STQ_BUF_COUNT-1:0] oh;
    oh      = '0;
    oh[ptr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/stq_drain_obuf.sv
// Drain output request register: captures the read entry, holds it under back-pressure and
// reports the entries to free on acceptance. STQ_DRAIN_MERGE_EN adds same-dword store merging.
module stq_drain_obuf
  import stq_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned ADDR_W    = 40,
  parameter int unsigned BUF_COUNT = STQ_BUF_COUNT,
  localparam int unsigned BE_W     = WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 accept,
`ifdef STQ_DRAIN_MERGE_EN
  input  logic                 merge,
  output logic                 merged,
`endif
  input  logic [STQ_PTR_W-1:0] rd_idx,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic [WIDTH-1:0]     rd_data,
  input  logic [BE_W-1:0]      rd_be,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [WIDTH-1:0]     wr_data,
  output logic [BE_W-1:0]      wr_be,
  output logic [BUF_COUNT-1:0] free_en
);

  stq_ptr_t idx0_q;

`ifdef STQ_DRAIN_MERGE_EN
  logic [WIDTH-1:0] merge_data;
  logic             merged_q;
  stq_ptr_t         idx1_q;

  // Younger store wins on the bytes it enables.
  always_comb begin
    merge_data = wr_data;
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (rd_be[b]) merge_data[b*8 +: 8] = rd_data[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      merged_q <= 1'b0;
      idx1_q   <= '0;
    end else if (load) begin
      merged_q <= 1'b0;
    end else if (merge) begin
      merged_q <= 1'b1;
      idx1_q   <= rd_idx;
    end
  end

  assign merged = merged_q;
`endif

  // Request payload; load and merge are mutually exclusive (merge only under !wr_ready).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_addr <= '0;
      wr_data <= '0;
      wr_be   <= '0;
      idx0_q  <= '0;
    end else if (load) begin
      wr_addr <= rd_addr;
      wr_data <= rd_data;
      wr_be   <= rd_be;
      idx0_q  <= rd_idx;
    end
`ifdef STQ_DRAIN_MERGE_EN
    else if (merge) begin
      wr_data <= merge_data;
      wr_be   <= wr_be | rd_be;
    end
`endif
  end

  always_comb begin
    free_en = '0;
    if (accept) free_en = BUF_COUNT'(stq_onehot(idx0_q));
`ifdef STQ_DRAIN_MERGE_EN
    if (accept && merged_q) free_en = free_en | BUF_COUNT'(stq_onehot(idx1_q));
`endif
  end

endmodule

// File: rtl/stq_drain.sv
// In-order store-queue drain: pending counter, head pointer and request FSM feeding the L1D
// write port. Optional store merging is enabled with STQ_DRAIN_MERGE_EN.
module stq_drain
  import stq_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned ADDR_W    = 40,
  parameter int unsigned BUF_COUNT = STQ_BUF_COUNT,
  localparam int unsigned BE_W     = WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           commit_cnt,
  output logic [BUF_COUNT-1:0] rd_en,
  input  logic [WIDTH-1:0]     rd_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic [BE_W-1:0]      rd_be,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [WIDTH-1:0]     wr_data,
  output logic [BE_W-1:0]      wr_be,
  output logic [BUF_COUNT-1:0] free_en,
  output logic [6:0]           pend_cnt
);

  drain_state_e state_q, state_d;
  stq_ptr_t     head_q;
  logic [6:0]   pend_q;
  logic         has_pend;
  logic         accept;
  logic         rd_fire;
  logic         rd_take;

  assign has_pend = (pend_q != 7'd0);
  assign accept   = (state_q == DRAIN_FULL) & wr_ready;
  assign rd_fire  = has_pend & ((state_q == DRAIN_EMPTY) | wr_ready);

`ifdef STQ_DRAIN_MERGE_EN
  logic merged;
  logic mrg_probe;
  logic mrg_fire;

  // Probe the head entry while stalled so its address can be compared; an unmatched probe is discarded.
  assign mrg_probe = (state_q == DRAIN_FULL) & ~wr_ready & has_pend & ~merged;
  assign mrg_fire  = mrg_probe & (rd_addr[ADDR_W-1:3] == wr_addr[ADDR_W-1:3]);
  assign rd_take   = rd_fire | mrg_fire;
  assign rd_en     = (rd_fire | mrg_probe) ? BUF_COUNT'(stq_onehot(head_q)) : '0;
`else
  assign rd_take   = rd_fire;
  assign rd_en     = rd_fire ? BUF_COUNT'(stq_onehot(head_q)) : '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DRAIN_EMPTY;
      head_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_q + 7'(commit_cnt) - 7'(rd_take);
      if (rd_take) head_q <= head_q + stq_ptr_t'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DRAIN_EMPTY: if (rd_fire) state_d = DRAIN_FULL;
      DRAIN_FULL:  if (wr_ready && !rd_fire) state_d = DRAIN_EMPTY;
      default:     state_d = DRAIN_EMPTY;
    endcase
  end

  assign wr_valid = (state_q == DRAIN_FULL);
  assign pend_cnt = pend_q;

  stq_drain_obuf #(
    .WIDTH     (WIDTH),
    .ADDR_W    (ADDR_W),
    .BUF_COUNT (BUF_COUNT)
  ) u_obuf (
    .clk     (clk),
    .rst     (rst),
    .load    (rd_fire),
    .accept  (accept),
`ifdef STQ_DRAIN_MERGE_EN
    .merge   (mrg_fire),
    .merged  (merged),
`endif
    .rd_idx  (head_q),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_be   (rd_be),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_be   (wr_be),
    .free_en (free_en)
  );

  // Allocation must never over-commit the queue; commit width is at most two.
  a_no_overcommit: assert property (@(posedge clk) disable iff (!rst)
    (8'(pend_q) + 8'(commit_cnt)) <= 8'(BUF_COUNT));
  a_commit_range: assert property (@(posedge clk) disable iff (!rst) commit_cnt != 2'd3);

endmodule

// File: tb/tb_stq_drain.sv
// Bench for stq_drain: behavioural array + queue model of committed entries, directed
// scenarios with literal expectations, then randomized commit/back-pressure traffic.
module tb_stq_drain;

  localparam int unsigned WIDTH     = 64;
  localparam int unsigned ADDR_W    = 40;
  localparam int unsigned BUF_COUNT = 64;
  localparam int unsigned BE_W      = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           commit_cnt = 2'd0;
  logic [BUF_COUNT-1:0] rd_en;
  logic [WIDTH-1:0]     rd_data;
  logic [ADDR_W-1:0]    rd_addr;
  logic [BE_W-1:0]      rd_be;
  logic                 wr_valid;
  logic                 wr_ready = 1'b0;
  logic [ADDR_W-1:0]    wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic [BE_W-1:0]      wr_be;
  logic [BUF_COUNT-1:0] free_en;
  logic [6:0]           pend_cnt;

  always #5 clk = ~clk;

  stq_drain dut (
    .clk(clk), .rst(rst), .commit_cnt(commit_cnt), .rd_en(rd_en),
    .rd_data(rd_data), .rd_addr(rd_addr), .rd_be(rd_be),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .free_en(free_en), .pend_cnt(pend_cnt)
  );

  // Store-queue data/address array contents and its combinational read port.
  logic [ADDR_W-1:0] m_addr [BUF_COUNT];
  logic [WIDTH-1:0]  m_data [BUF_COUNT];
  logic [BE_W-1:0]   m_be   [BUF_COUNT];

  always_comb begin
    rd_addr = '0;
    rd_data = '0;
    rd_be   = '0;
    for (int i = 0; i < BUF_COUNT; i++) begin
      if (rd_en[i]) begin
        rd_addr = m_addr[i];
        rd_data = m_data[i];
        rd_be   = m_be[i];
      end
    end
  end

  // Model: committed-but-unread entry indices in order, plus the one held request.
  int pending[$];
  int issued  = 0;
  bit h_valid = 1'b0;
  int h_idx   = 0;
  int cur_c   = 0;
  bit cur_r   = 1'b0;
  bit cur_rd  = 1'b0;
  bit rand_fill = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fill(input int i);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    m_addr[i] = r[ADDR_W-1:0];
    m_data[i] = {$urandom(), $urandom()};
    m_be[i]   = 8'($urandom());
  endtask

  // Apply inputs just after a rising edge and check every output at the following falling edge.
  task automatic drive(input int c, input bit r);
    logic [63:0] e_rd;
    logic [63:0] e_free;
    commit_cnt = 2'(c);
    wr_ready   = r;
    cur_c  = c;
    cur_r  = r;
    cur_rd = (pending.size() != 0) && (!h_valid || r);
    e_rd   = cur_rd ? (64'd1 << pending[0]) : 64'd0;
    e_free = (h_valid && r) ? (64'd1 << h_idx) : 64'd0;
    @(negedge clk);
    chk("rd_en", 128'(rd_en), 128'(e_rd));
    chk("pend_cnt", 128'(pend_cnt), 128'(pending.size()));
    chk("wr_valid", 128'(wr_valid), 128'(h_valid));
    chk("free_en", 128'(free_en), 128'(e_free));
    if (h_valid) begin
      chk("wr_addr", 128'(wr_addr), 128'(m_addr[h_idx]));
      chk("wr_data", 128'(wr_data), 128'(m_data[h_idx]));
      chk("wr_be", 128'(wr_be), 128'(m_be[h_idx]));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (h_valid && cur_r) h_valid = 1'b0;
    if (cur_rd) begin
      h_idx   = pending.pop_front();
      h_valid = 1'b1;
    end
    for (int k = 0; k < cur_c; k++) begin
      if (rand_fill) fill(issued);
      pending.push_back(issued);
      issued = (issued + 1) % BUF_COUNT;
    end
    #1;
  endtask

  task automatic step(input int c, input bit r);
    drive(c, r);
    advance();
  endtask

  // Asynchronous reset entered mid-cycle; outputs must clear at once and stay clear through the edge.
  task automatic do_reset();
    rst = 1'b0;
    commit_cnt = 2'd0;
    wr_ready   = 1'b0;
    #1;
    chk("rst_wr_valid", 128'(wr_valid), 128'(0));
    chk("rst_rd_en", 128'(rd_en), 128'(0));
    chk("rst_free_en", 128'(free_en), 128'(0));
    chk("rst_pend_cnt", 128'(pend_cnt), 128'(0));
    chk("rst_wr_addr", 128'(wr_addr), 128'(0));
    chk("rst_wr_data", 128'(wr_data), 128'(0));
    chk("rst_wr_be", 128'(wr_be), 128'(0));
    @(posedge clk);
    #1;
    chk("rst_edge_wr_valid", 128'(wr_valid), 128'(0));
    chk("rst_edge_pend_cnt", 128'(pend_cnt), 128'(0));
    rst = 1'b1;
    pending.delete();
    issued  = 0;
    h_valid = 1'b0;
    cur_c   = 0;
    cur_rd  = 1'b0;
  endtask

  task automatic drain_all(input string name);
    int guard;
    guard = 0;
    while ((pending.size() != 0 || h_valid) && guard < 200) begin
      step(0, 1'b1);
      guard++;
    end
    chk(name, 128'(pending.size() != 0 || h_valid), 128'(0));
  endtask

  initial begin
    logic [63:0] exp_seq [4];
    int seq;
    int n;
    for (int i = 0; i < BUF_COUNT; i++) fill(i);
    #2;
    do_reset();

    // Single store through the pipe.
    m_addr[0] = 40'h1000;
    m_data[0] = 64'hDEAD;
    m_be[0]   = 8'hFF;
    step(1, 1'b1);
    drive(0, 1'b1);
    chk("t2_rd_en", 128'(rd_en), 128'h1);
    advance();
    drive(0, 1'b1);
    chk("t2_wr_valid", 128'(wr_valid), 128'h1);
    chk("t2_wr_addr", 128'(wr_addr), 128'h1000);
    chk("t2_wr_data", 128'(wr_data), 128'hDEAD);
    chk("t2_wr_be", 128'(wr_be), 128'hFF);
    chk("t2_free_en", 128'(free_en), 128'h1);
    advance();
    drive(0, 1'b1);
    chk("t2_idle", 128'(wr_valid), 128'h0);
    advance();

    // Back-pressure: three commits, L1D stalls five cycles.
    for (int i = 1; i <= 3; i++) begin
      m_addr[i] = 40'h3000 + 40'(i);
      m_data[i] = 64'h5555_0000 + 64'(i);
      m_be[i]   = 8'h0F;
    end
    step(2, 1'b0);
    drive(1, 1'b0);
    chk("t3_rd_pulse", 128'(rd_en), 128'h2);
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b0);
      chk("t3_hold_pend", 128'(pend_cnt), 128'd2);
      chk("t3_hold_rd_en", 128'(rd_en), 128'h0);
      chk("t3_hold_addr", 128'(wr_addr), 128'h3001);
      advance();
    end
    drive(0, 1'b1);
    chk("t3_free", 128'(free_en), 128'h2);
    chk("t3_next_rd", 128'(rd_en), 128'h4);
    advance();
    drain_all("t3_drain_timeout");

    // Wrap: bring head to 62 then commit four entries.
    rand_fill = 1'b1;
    for (int i = 0; i < 29; i++) step(2, 1'b1);
    drain_all("t4_drain_timeout");
    chk("t4_head_at_62", 128'(issued), 128'd62);
    exp_seq[0] = 64'd1 << 62;
    exp_seq[1] = 64'd1 << 63;
    exp_seq[2] = 64'd1;
    exp_seq[3] = 64'd2;
    seq = 0;
    for (int k = 0; k < 10; k++) begin
      drive((k < 2) ? 2 : 0, 1'b1);
      if (rd_en != '0) begin
        if (seq < 4) chk("t4_wrap_order", 128'(rd_en), 128'(exp_seq[seq]));
        else chk("t4_extra_read", 128'(rd_en), 128'h0);
        seq++;
      end
      advance();
    end
    chk("t4_read_count", 128'(seq), 128'd4);
    chk("t4_pend_end", 128'(pend_cnt), 128'd0);

    // Two commits per cycle with a ready port: occupancy climbs one per cycle up to the queue limit.
    n = 1;
    while ((pending.size() + int'(h_valid) + 2) <= BUF_COUNT && n < 100) begin
      drive(2, 1'b1);
      if (n == 10) chk("t5_pend_growth", 128'(pend_cnt), 128'd10);
      advance();
      n++;
    end
    drain_all("t5_drain_timeout");

    // Reset with a request outstanding.
    step(1, 1'b0);
    step(0, 1'b0);
    drive(0, 1'b0);
    chk("t1_held_before_reset", 128'(wr_valid), 128'h1);
    do_reset();

    // Randomized traffic at three back-pressure levels.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 1000; i++) begin
        int c;
        bit r;
        c = int'($urandom_range(0, 2));
        while (c > 0 && (pending.size() + int'(h_valid) + c) > BUF_COUNT) c--;
        r = (ph == 0) ? ($urandom_range(0, 3) == 0) :
            (ph == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        drive(c, r);
        if (i == 500 && wr_valid) do_reset();
        else advance();
      end
    end
    drain_all("rand_drain_timeout");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
